// File: rtl/qos_pkg.sv
// Shared definitions for the QoS channel selector: state encoding,
// reset defaults and priority-list field access.
package qos_pkg;

  typedef enum logic [1:0] {
    ST_FIXED   = 2'd0,
    ST_AUTO    = 2'd1,
    ST_HOLDOFF = 2'd2,
    ST_NONE    = 2'd3
  } state_t;

  localparam logic [7:0] PRIO_DEFAULT = 8'hE4;
  localparam int         NUM_CH       = 4;
  localparam int         PRIO_W       = 2;

  // Channel number held in priority slot idx (slot 0 = highest priority).
  function automatic logic [1:0] prio_field(input logic [7:0] prio, input int idx);
    return prio[idx*PRIO_W +: PRIO_W];
  endfunction

endpackage

// File: rtl/qos_best_pick.sv
// Picks the highest-priority healthy channel from the 4-entry priority list.
// A channel missing from the list can never be picked; for duplicated
// entries the earliest slot decides.
module qos_best_pick
  import qos_pkg::*;
(
  input  logic [NUM_CH-1:0] healthy,
  input  logic [7:0]        prio,
  output logic [1:0]        best,
  output logic              best_valid
);

  // Scan lowest to highest priority so the highest-priority hit is written last.
  always_comb begin
    best       = '0;
    best_valid = 1'b0;
    for (int i = NUM_CH-1; i >= 0; i--) begin
      if (healthy[prio_field(prio, i)]) begin
        best       = prio_field(prio, i);
        best_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/qos_channel_selector.sv
// QoS channel selector for the TS mux: shadows config on valid_config,
// chooses active_channel (manual / fixed / automatic fallback with
// hold-off against flapping) and generates the periodic error-counter clear.
module qos_channel_selector
  import qos_pkg::*;
#(
  parameter logic [7:0] ERR_THRESH     = 8'd16,
  parameter int         HOLDOFF_CYCLES = 1024,
  parameter int         HOLD_W         = 11
)(
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_config,
  input  logic        fallback_enable,
  input  logic        manual_enable,
  input  logic [1:0]  manual_channel,
  input  logic [7:0]  channel_priority,
  input  logic [19:0] reset_timer,
  input  logic [3:0]  signal_present,
  input  logic [7:0]  error_count_ch0,
  input  logic [7:0]  error_count_ch1,
  input  logic [7:0]  error_count_ch2,
  input  logic [7:0]  error_count_ch3,
  output logic [1:0]  active_channel,
  output logic        switch_pulse,
  output logic        no_healthy,
  output logic        err_clear,
  output logic [1:0]  fsm_state
);

  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLDOFF_CYCLES - 1);

  // Shadowed configuration; the FSM only ever looks at these copies.
  logic        cfg_fallback;
  logic        cfg_manual;
  logic [1:0]  cfg_manual_ch;
  logic [7:0]  cfg_prio;
  logic [19:0] cfg_timer;

  logic [19:0]              win_cnt;
  logic [HOLD_W-1:0]        hold;
  state_t                   state;
  logic [NUM_CH-1:0][7:0]   err;
  logic [NUM_CH-1:0]        healthy;
  logic [1:0]               best;
  logic                     best_valid;
  logic [1:0]               target;

  assign err = {error_count_ch3, error_count_ch2, error_count_ch1, error_count_ch0};

  for (genvar i = 0; i < NUM_CH; i++) begin : g_health
    assign healthy[i] = signal_present[i] && (err[i] < ERR_THRESH);
  end

  qos_best_pick u_best_pick (
    .healthy    (healthy),
    .prio       (cfg_prio),
    .best       (best),
    .best_valid (best_valid)
  );

  assign target    = cfg_manual ? cfg_manual_ch : (!cfg_fallback ? cfg_prio[1:0] : best);
  assign fsm_state = state;

  // Config shadow: capture all config inputs on the valid_config pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_fallback  <= 1'b0;
      cfg_manual    <= 1'b0;
      cfg_manual_ch <= 2'd0;
      cfg_prio      <= PRIO_DEFAULT;
      cfg_timer     <= '0;
    end else if (valid_config) begin
      cfg_fallback  <= fallback_enable;
      cfg_manual    <= manual_enable;
      cfg_manual_ch <= manual_channel;
      cfg_prio      <= channel_priority;
      cfg_timer     <= reset_timer;
    end
  end

  // Error window: count 0..timer-1, pulse err_clear on wrap; a config load restarts it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_cnt   <= '0;
      err_clear <= 1'b0;
    end else if (valid_config || cfg_timer == '0) begin
      win_cnt   <= '0;
      err_clear <= 1'b0;
    end else if (win_cnt == cfg_timer - 20'd1) begin
      win_cnt   <= '0;
      err_clear <= 1'b1;
    end else begin
      win_cnt   <= win_cnt + 20'd1;
      err_clear <= 1'b0;
    end
  end

  // Selection FSM: manual/fixed overrides first, then loss of health, then
  // hold-off timing, then automatic (revertive) switching.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= ST_FIXED;
      active_channel <= 2'd0;
      switch_pulse   <= 1'b0;
      no_healthy     <= 1'b0;
      hold           <= '0;
    end else begin
      switch_pulse <= 1'b0;
      if (cfg_manual || !cfg_fallback) begin
        state          <= ST_FIXED;
        no_healthy     <= 1'b0;
        active_channel <= target;
        switch_pulse   <= (target != active_channel);
      end else if (!best_valid) begin
        state      <= ST_NONE;
        no_healthy <= 1'b1;
      end else begin
        no_healthy <= 1'b0;
        case (state)
          // Recovery from no-health: settle in AUTO first, switch on the next evaluation.
          ST_NONE: state <= ST_AUTO;
          ST_HOLDOFF: begin
            if (hold != '0) hold <= hold - HOLD_W'(1);
            if (hold <= HOLD_W'(1)) state <= ST_AUTO;
          end
          default: begin
            if (best != active_channel) begin
              active_channel <= best;
              switch_pulse   <= 1'b1;
              hold           <= HOLD_LOAD;
              state          <= ST_HOLDOFF;
            end else begin
              state <= ST_AUTO;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_qos_channel_selector.sv
// Self-checking bench for qos_channel_selector: directed scenarios with
// hand-computed expectations plus a randomized phase, all checked every
// cycle against a behavioural model of the selection rules.
module tb_qos_channel_selector;

  localparam int HOLDOFF = 1024;
  localparam int THRESH  = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_config = 1'b0;
  logic        fallback_enable = 1'b0;
  logic        manual_enable = 1'b0;
  logic [1:0]  manual_channel = '0;
  logic [7:0]  channel_priority = 8'hE4;
  logic [19:0] reset_timer = '0;
  logic [3:0]  signal_present = 4'hF;
  logic [7:0]  error_count_ch0 = '0;
  logic [7:0]  error_count_ch1 = '0;
  logic [7:0]  error_count_ch2 = '0;
  logic [7:0]  error_count_ch3 = '0;
  logic [1:0]  active_channel;
  logic        switch_pulse;
  logic        no_healthy;
  logic        err_clear;
  logic [1:0]  fsm_state;

  qos_channel_selector dut (
    .clk              (clk),
    .rst              (rst),
    .valid_config     (valid_config),
    .fallback_enable  (fallback_enable),
    .manual_enable    (manual_enable),
    .manual_channel   (manual_channel),
    .channel_priority (channel_priority),
    .reset_timer      (reset_timer),
    .signal_present   (signal_present),
    .error_count_ch0  (error_count_ch0),
    .error_count_ch1  (error_count_ch1),
    .error_count_ch2  (error_count_ch2),
    .error_count_ch3  (error_count_ch3),
    .active_channel   (active_channel),
    .switch_pulse     (switch_pulse),
    .no_healthy       (no_healthy),
    .err_clear        (err_clear),
    .fsm_state        (fsm_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Model: shadow config, expected outputs, hold-off bookkeeping as elapsed time.
  bit m_fb, m_man, m_pulse, m_nh, m_clr, m_in_hold;
  int m_mch, m_prio, m_timer, m_act, m_st, m_win, m_since;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_fb = 0; m_man = 0; m_mch = 0; m_prio = 'hE4; m_timer = 0;
    m_act = 0; m_st = 0; m_pulse = 0; m_nh = 0; m_clr = 0;
    m_win = 0; m_in_hold = 0; m_since = 0;
  endtask

  // Advance the model by one clock edge using the inputs currently applied,
  // then let the DUT take the same edge and compare all outputs.
  task automatic tick();
    int errs[4];
    bit h[4];
    bit bv;
    int best, new_act, ch;
    errs[0] = error_count_ch0; errs[1] = error_count_ch1;
    errs[2] = error_count_ch2; errs[3] = error_count_ch3;
    for (int i = 0; i < 4; i++) h[i] = signal_present[i] && (errs[i] < THRESH);
    bv = 0; best = 0;
    for (int k = 0; k < 4; k++) begin
      ch = (m_prio >> (2*k)) & 3;
      if (!bv && h[ch]) begin bv = 1; best = ch; end
    end
    new_act = m_act;
    if (m_man || !m_fb) begin
      new_act = m_man ? m_mch : (m_prio & 3);
      m_st = 0; m_nh = 0; m_in_hold = 0;
    end else if (!bv) begin
      m_st = 3; m_nh = 1; m_in_hold = 0;
    end else if (m_nh) begin
      m_st = 1; m_nh = 0;
    end else if (m_in_hold) begin
      m_since++;
      if (m_since >= HOLDOFF - 1) begin m_in_hold = 0; m_st = 1; end
      else m_st = 2;
    end else if (best != m_act) begin
      new_act = best; m_in_hold = 1; m_since = 0; m_st = 2;
    end else begin
      m_st = 1;
    end
    m_pulse = (new_act != m_act);
    m_act = new_act;
    if (valid_config || m_timer == 0) begin
      m_win = 0; m_clr = 0;
    end else if (m_win == m_timer - 1) begin
      m_win = 0; m_clr = 1;
    end else begin
      m_win++; m_clr = 0;
    end
    if (valid_config) begin
      m_fb = fallback_enable; m_man = manual_enable; m_mch = manual_channel;
      m_prio = channel_priority; m_timer = reset_timer;
    end
    @(posedge clk);
    #1;
    chk("active_channel", active_channel, m_act);
    chk("switch_pulse", switch_pulse, m_pulse);
    chk("no_healthy", no_healthy, m_nh);
    chk("err_clear", err_clear, m_clr);
    chk("fsm_state", fsm_state, m_st);
  endtask

  // Asynchronous reset between edges; outputs must drop before any clock.
  task automatic do_reset();
    #2 rst = 1'b1;
    valid_config = 1'b0;
    #1;
    chk("rst_active_channel", active_channel, 0);
    chk("rst_switch_pulse", switch_pulse, 0);
    chk("rst_no_healthy", no_healthy, 0);
    chk("rst_err_clear", err_clear, 0);
    chk("rst_fsm_state", fsm_state, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic apply_cfg(input bit fb, input bit man, input int mch, input int prio, input int tmr);
    fallback_enable  = fb;
    manual_enable    = man;
    manual_channel   = 2'(mch);
    channel_priority = 8'(prio);
    reset_timer      = 20'(tmr);
    valid_config     = 1'b1;
    tick();
    valid_config     = 1'b0;
  endtask

  task automatic set_health(input logic [3:0] sp, input int e0, input int e1, input int e2, input int e3);
    signal_present  = sp;
    error_count_ch0 = 8'(e0); error_count_ch1 = 8'(e1);
    error_count_ch2 = 8'(e2); error_count_ch3 = 8'(e3);
  endtask

  function automatic int rand_err();
    case ($urandom_range(0, 4))
      0: return 0;
      1: return THRESH - 1;
      2: return THRESH;
      3: return THRESH + 1;
      default: return int'($urandom_range(0, 255));
    endcase
  endfunction

  initial begin
    int cnt;
    model_reset();
    do_reset();

    // Manual override to channel 2.
    apply_cfg(0, 1, 2, 'hE4, 0);
    tick();
    chk("manual_active", active_channel, 2);
    chk("manual_pulse", switch_pulse, 1);
    chk("manual_state", fsm_state, 0);
    tick();
    chk("manual_pulse_once", switch_pulse, 0);

    // Automatic fallback, hold-off, then revertive switch back.
    do_reset();
    set_health(4'hF, 0, 0, 0, 0);
    apply_cfg(1, 0, 0, 'hE4, 0);
    tick();
    chk("auto_state", fsm_state, 1);
    error_count_ch0 = 8'd16;
    tick();
    chk("fail_active", active_channel, 1);
    chk("fail_pulse", switch_pulse, 1);
    chk("fail_state", fsm_state, 2);
    error_count_ch0 = 8'd0;
    repeat (HOLDOFF - 1) tick();
    chk("holdoff_no_revert", active_channel, 1);
    chk("holdoff_done_state", fsm_state, 1);
    tick();
    chk("revert_active", active_channel, 0);
    chk("revert_pulse", switch_pulse, 1);

    // Manual override during hold-off, then async reset mid hold-off.
    apply_cfg(1, 1, 3, 'hE4, 0);
    tick();
    chk("ovr_active", active_channel, 3);
    chk("ovr_state", fsm_state, 0);
    apply_cfg(1, 0, 0, 'hE4, 0);
    tick();
    chk("reauto_state", fsm_state, 2);
    chk("reauto_active", active_channel, 0);
    repeat (5) tick();
    do_reset();

    // No healthy channel, then recovery on channel 3.
    set_health(4'hF, 0, 0, 0, 0);
    apply_cfg(1, 0, 0, 'hE4, 0);
    tick();
    signal_present = 4'b0100;
    tick();
    chk("to_ch2", active_channel, 2);
    signal_present = 4'b0000;
    tick();
    chk("none_flag", no_healthy, 1);
    chk("none_state", fsm_state, 3);
    chk("none_keep", active_channel, 2);
    signal_present = 4'b1000;
    tick();
    tick();
    chk("recover_active", active_channel, 3);
    chk("recover_flag", no_healthy, 0);

    // Error window periods.
    do_reset();
    apply_cfg(0, 0, 0, 'hE4, 5);
    cnt = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (err_clear) begin
        cnt++;
        chk("clr_phase", (i + 1) % 5, 0);
      end
    end
    chk("clr_count5", cnt, 10);
    apply_cfg(0, 0, 0, 'hE4, 1);
    cnt = 0;
    repeat (10) begin tick(); if (err_clear) cnt++; end
    chk("clr_count1", cnt, 10);
    apply_cfg(0, 0, 0, 'hE4, 0);
    cnt = 0;
    repeat (100) begin tick(); if (err_clear) cnt++; end
    chk("clr_count0", cnt, 0);

    // Priority list naming only channel 1, which is unhealthy.
    do_reset();
    set_health(4'b1101, 0, 0, 0, 0);
    apply_cfg(1, 0, 0, 'h55, 0);
    tick();
    chk("absent_none", no_healthy, 1);
    cnt = 0;
    repeat (20) begin tick(); if (switch_pulse) cnt++; end
    chk("absent_no_switch", cnt, 0);
    chk("absent_active", active_channel, 0);

    // Randomized phase.
    do_reset();
    for (int c = 0; c < 9000; c++) begin
      if ($urandom_range(0, 39) == 0)
        set_health(4'($urandom_range(0, 15)), rand_err(), rand_err(), rand_err(), rand_err());
      if ($urandom_range(0, 299) == 0) begin
        fallback_enable  = ($urandom_range(0, 4) != 0);
        manual_enable    = ($urandom_range(0, 5) == 0);
        manual_channel   = 2'($urandom_range(0, 3));
        channel_priority = 8'($urandom_range(0, 255));
        reset_timer      = 20'($urandom_range(0, 9));
        valid_config     = 1'b1;
      end
      tick();
      valid_config = 1'b0;
      if (c == 4500) do_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
